// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings and helpers for the handshaked MEM stage.
// Contents: access-size codes, FSM state type, byte-enable mask and
// misalignment helpers (both work on the low three address bits).
package mem_stage_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic {IDLE, REQ} state_t;

    // Access-size mask shifted to its lane; callers keep the low DATA_W/8 bits.
    function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] lane);
        logic [7:0] m;
        m = size == SIZE_B ? 8'h01 : size == SIZE_H ? 8'h03 : size == SIZE_W ? 8'h0f : 8'hff;
        return m << lane;
    endfunction

    function automatic logic misalign(input logic [1:0] size, input logic [2:0] addr);
        return size == SIZE_H ? addr[0] : size == SIZE_W ? |addr[1:0] : size == SIZE_D ? |addr : 1'b0;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed lane of a read word and sign/zero extends it.
// Ports: data (bus read word), lane (byte offset within the word), size (access
// size code), uns (zero-extend), dout (extended result, DATA_W wide).
module load_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LW = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [LW-1:0]     lane,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] w;

    assign sh = data >> {lane, 3'b000};

    // A word is the full datum on a 32-bit path but must be extended on 64.
    generate
        if (DATA_W == 64) begin : g_w64
            assign w = {{32{~uns & sh[31]}}, sh[31:0]};
        end else begin : g_w32
            assign w = sh;
        end
    endgenerate

    assign dout = size == SIZE_B ? {{(DATA_W-8){~uns & sh[7]}}, sh[7:0]} :
                  size == SIZE_H ? {{(DATA_W-16){~uns & sh[15]}}, sh[15:0]} :
                  size == SIZE_W ? w : sh;

endmodule

// File: rtl/stage_mem_hs.sv
// stage_mem_hs: MEM pipeline stage with a req/ack data-memory handshake.
// Ports: Clk/Rst_n (async active-low); in_* EX/MEM entry; Stall holds upstream;
// PCSrc/Btarg_or_Jtarg redirect IF; mem_* data-memory bus (mem_ack/mem_rdata
// returned by memory); out_* registered MEM/WB entry.
// Optional: define MEM_TIMEOUT_EN to abort a request after TIMEOUT_CYC cycles
// in REQ and report it through out_BusErr.
module stage_mem_hs
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RW_W = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                in_valid,
    input  logic [ADDR_W-1:0]   in_Btarg,
    input  logic [ADDR_W-1:0]   in_Jtarg,
    input  logic [DATA_W-1:0]   in_busB,
    input  logic [DATA_W-1:0]   in_ALUout,
    input  logic [RW_W-1:0]     in_Rw,
    input  logic                in_Zero,
    input  logic                in_Overflow,
    input  logic                in_RegWr,
    input  logic                in_MemtoReg,
    input  logic                in_MemWr,
    input  logic                in_MemRd,
    input  logic                in_Branch,
    input  logic                in_Jump,
    input  logic [1:0]          in_Size,
    input  logic                in_Unsigned,
    output logic                Stall,
    output logic                PCSrc,
    output logic [ADDR_W-1:0]   Btarg_or_Jtarg,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                out_valid,
    output logic                out_RegWr,
    output logic                out_MemtoReg,
    output logic                out_Overflow,
    output logic                out_AddrErr,
    output logic                out_BusErr,
    output logic [DATA_W-1:0]   out_Dout,
    output logic [DATA_W-1:0]   out_ALUout,
    output logic [RW_W-1:0]     out_Rw
);
    localparam int BW = DATA_W / 8;
    localparam int LW = $clog2(BW);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        lane;
    logic [7:0]        bm;
    logic [DATA_W-1:0] wdata, ld_data, alu_q;
    logic [RW_W-1:0]   rw_q;
    logic [LW-1:0]     lane_q;
    logic [1:0]        size_q;
    logic              mem_op, mis, issue, done, tmo;
    logic              regwr_q, m2r_q, ovf_q, uns_q;

    assign addr = in_ALUout[ADDR_W-1:0];
    assign lane = 3'(addr[LW-1:0]);
    assign bm = be_mask(in_Size, lane);
    assign mem_op = in_MemRd | in_MemWr;
    assign mis = misalign(in_Size, addr[2:0]) | (DATA_W == 32 && in_Size == SIZE_D);
    assign issue = in_valid & mem_op & ~mis;
    assign done = mem_ack | tmo;
    assign mem_req = state == REQ;
    assign PCSrc = in_valid & (in_Jump | (in_Branch & in_Zero));
    assign Btarg_or_Jtarg = in_Jump ? in_Jtarg : in_Btarg;
    assign wdata = in_Size == SIZE_B ? {BW{in_busB[7:0]}} :
                   in_Size == SIZE_H ? {(BW/2){in_busB[15:0]}} :
                   in_Size == SIZE_W ? {(BW/4){in_busB[31:0]}} : in_busB;

`ifdef MEM_TIMEOUT_EN
    localparam int CL = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = CL < 8 ? 8 : (CL > 16 ? 16 : CL);
    logic [CW-1:0] cnt;
    // Zero whenever idle, so every request starts counting from zero.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) cnt <= '0;
        else cnt <= state == REQ ? cnt + 1'b1 : '0;
    end
    assign tmo = state == REQ && !mem_ack && cnt == CW'(TIMEOUT_CYC - 1);
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYC;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state == IDLE ? (issue ? REQ : IDLE) : (done ? IDLE : REQ);
        Stall = state == IDLE ? issue : ~done;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mem_addr <= '0;
            mem_be <= '0;
            mem_wdata <= '0;
            mem_we <= 1'b0;
            alu_q <= '0;
            rw_q <= '0;
            lane_q <= '0;
            size_q <= '0;
            regwr_q <= 1'b0;
            m2r_q <= 1'b0;
            ovf_q <= 1'b0;
            uns_q <= 1'b0;
        end else if (state == IDLE && issue) begin
            mem_addr <= {addr[ADDR_W-1:LW], LW'(0)};
            mem_be <= bm[BW-1:0];
            mem_wdata <= wdata;
            mem_we <= in_MemWr;
            alu_q <= in_ALUout;
            rw_q <= in_Rw;
            lane_q <= addr[LW-1:0];
            size_q <= in_Size;
            regwr_q <= in_RegWr;
            m2r_q <= in_MemtoReg;
            ovf_q <= in_Overflow;
            uns_q <= in_Unsigned;
        end else if (state == REQ && done) begin
            mem_we <= 1'b0;
        end
    end

    load_align #(.DATA_W(DATA_W)) u_align (
        .data(mem_rdata),
        .lane(lane_q),
        .size(size_q),
        .uns(uns_q),
        .dout(ld_data)
    );

    // MEM/WB: stall cycles insert bubbles so WB never sees a repeated entry.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid <= 1'b0;
            out_RegWr <= 1'b0;
            out_MemtoReg <= 1'b0;
            out_Overflow <= 1'b0;
            out_AddrErr <= 1'b0;
            out_BusErr <= 1'b0;
            out_Dout <= '0;
            out_ALUout <= '0;
            out_Rw <= '0;
        end else if (state == REQ) begin
            out_valid <= done;
            out_RegWr <= mem_ack & regwr_q & ~mem_we;
            if (done) begin
                out_MemtoReg <= m2r_q;
                out_Overflow <= ovf_q;
                out_AddrErr <= 1'b0;
                out_BusErr <= ~mem_ack;
                out_Dout <= mem_ack & ~mem_we ? ld_data : '0;
                out_ALUout <= alu_q;
                out_Rw <= rw_q;
            end
        end else begin
            out_valid <= in_valid & ~issue;
            out_RegWr <= in_valid & ~issue & ~mem_op & in_RegWr;
            if (in_valid & ~issue) begin
                out_MemtoReg <= in_MemtoReg;
                out_Overflow <= in_Overflow;
                out_AddrErr <= mem_op;
                out_BusErr <= 1'b0;
                out_Dout <= '0;
                out_ALUout <= in_ALUout;
                out_Rw <= in_Rw;
            end
        end
    end

endmodule

// File: tb/tb_stage_mem_hs.sv
// tb_stage_mem_hs: scoreboard bench for stage_mem_hs with a random-latency memory.
module tb_stage_mem_hs;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        in_valid, in_Zero, in_Overflow, in_RegWr, in_MemtoReg;
    logic        in_MemWr, in_MemRd, in_Branch, in_Jump, in_Unsigned;
    logic [31:0] in_Btarg, in_Jtarg, in_busB, in_ALUout;
    logic [4:0]  in_Rw;
    logic [1:0]  in_Size;
    logic        Stall, PCSrc, mem_req, mem_we, mem_ack;
    logic [31:0] Btarg_or_Jtarg, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        out_valid, out_RegWr, out_MemtoReg, out_Overflow, out_AddrErr, out_BusErr;
    logic [31:0] out_Dout, out_ALUout;
    logic [4:0]  out_Rw;

    always #5 Clk = ~Clk;

    stage_mem_hs dut (
        .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_Btarg(in_Btarg), .in_Jtarg(in_Jtarg),
        .in_busB(in_busB), .in_ALUout(in_ALUout), .in_Rw(in_Rw), .in_Zero(in_Zero),
        .in_Overflow(in_Overflow), .in_RegWr(in_RegWr), .in_MemtoReg(in_MemtoReg),
        .in_MemWr(in_MemWr), .in_MemRd(in_MemRd), .in_Branch(in_Branch), .in_Jump(in_Jump),
        .in_Size(in_Size), .in_Unsigned(in_Unsigned), .Stall(Stall), .PCSrc(PCSrc),
        .Btarg_or_Jtarg(Btarg_or_Jtarg), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_RegWr(out_RegWr), .out_MemtoReg(out_MemtoReg),
        .out_Overflow(out_Overflow), .out_AddrErr(out_AddrErr), .out_BusErr(out_BusErr),
        .out_Dout(out_Dout), .out_ALUout(out_ALUout), .out_Rw(out_Rw)
    );

    typedef struct packed {
        logic valid; logic [31:0] btarg, jtarg, busb, alu; logic [4:0] rw;
        logic zero, ovf, regwr, m2r, memwr, memrd, branch, jump; logic [1:0] size; logic uns; int d;
    } op_t;
    typedef struct packed {
        logic adderr, regwr, m2r, ovf, chk_dout; logic [4:0] rw; logic [31:0] alu, dout;
    } wb_t;
    typedef struct packed {
        logic [31:0] addr, wdata; logic we; logic [3:0] be; int d;
    } bus_t;

    wb_t sb[$];
    bus_t bq[$];
    int checks = 0;
    int errors = 0;
    bit [7:0] mmod[int unsigned];
    bit [7:0] mbus[int unsigned];

    function automatic bit [7:0] init_b(int unsigned a);
        return 8'((a * 37) ^ (a >> 3) ^ 32'h5c);
    endfunction
    function automatic bit [7:0] mod_b(int unsigned a);
        return mmod.exists(a) ? mmod[a] : init_b(a);
    endfunction
    function automatic bit [7:0] bus_b(int unsigned a);
        return mbus.exists(a) ? mbus[a] : init_b(a);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic op_t mk(logic [31:0] alu, logic [4:0] rw, logic regwr, logic memrd,
                               logic memwr, logic [1:0] size, logic uns, logic [31:0] busb, int d);
        op_t o;
        o = '0;
        o.valid = 1'b1; o.alu = alu; o.rw = rw; o.regwr = regwr; o.memrd = memrd;
        o.memwr = memwr; o.size = size; o.uns = uns; o.busb = busb; o.d = d;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int kind, n;
        o = '0;
        o.valid = $urandom_range(0, 9) != 0;
        o.btarg = $urandom; o.jtarg = $urandom; o.busb = $urandom; o.rw = 5'($urandom);
        o.zero = 1'($urandom); o.ovf = 1'($urandom); o.regwr = 1'($urandom); o.m2r = 1'($urandom);
        o.branch = $urandom_range(0, 3) == 0; o.jump = $urandom_range(0, 3) == 0;
        kind = $urandom_range(0, 3);
        o.memrd = kind == 1 || kind == 3;
        o.memwr = kind >= 2;
        o.size = $urandom_range(0, 7) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
        n = 1 << o.size;
        o.alu = kind == 0 ? $urandom : 32'h100 + $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1) o.alu = o.alu & ~32'(n - 1);
        o.uns = 1'($urandom);
        o.d = $urandom_range(0, 4);
        return o;
    endfunction

    task automatic issue(op_t o);
        bit mem, mis, st_now;
        int n, stalls, exp_st;
        logic [31:0] v;
        wb_t w;
        bus_t b;
        in_valid = o.valid; in_Btarg = o.btarg; in_Jtarg = o.jtarg; in_busB = o.busb;
        in_ALUout = o.alu; in_Rw = o.rw; in_Zero = o.zero; in_Overflow = o.ovf;
        in_RegWr = o.regwr; in_MemtoReg = o.m2r; in_MemWr = o.memwr; in_MemRd = o.memrd;
        in_Branch = o.branch; in_Jump = o.jump; in_Size = o.size; in_Unsigned = o.uns;
        mem = o.memrd | o.memwr;
        n = 1 << o.size;
        mis = mem && (o.size == 2'd3 || (o.alu % n) != 0);
        exp_st = 0;
        if (o.valid) begin
            w = '0;
            w.rw = o.rw; w.alu = o.alu; w.m2r = o.m2r; w.ovf = o.ovf;
            if (!mem) w.regwr = o.regwr;
            else if (mis) w.adderr = 1'b1;
            else begin
                w.chk_dout = 1'b1;
                exp_st = 1 + o.d;
                b = '0;
                b.addr = o.alu & ~32'd3; b.we = o.memwr; b.d = o.d;
                for (int i = 0; i < 4; i++) begin
                    if (i >= o.alu[1:0] && i < o.alu[1:0] + n) b.be[i] = 1'b1;
                    b.wdata[8*i +: 8] = o.busb[8*(i % n) +: 8];
                end
                bq.push_back(b);
                if (o.memwr) begin
                    for (int i = 0; i < n; i++) mmod[o.alu + i] = o.busb[8*i +: 8];
                end else begin
                    v = 0;
                    for (int i = 0; i < n; i++) v = v | (32'(mod_b(o.alu + i)) << (8 * i));
                    if (!o.uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
                    w.regwr = o.regwr;
                    w.dout = v;
                end
            end
            sb.push_back(w);
        end
        stalls = 0;
        @(negedge Clk); #1;
        chk("PCSrc", PCSrc, o.valid & (o.jump | (o.branch & o.zero)));
        chk("Btarg_or_Jtarg", Btarg_or_Jtarg, o.jump ? o.jtarg : o.btarg);
        forever begin
            st_now = Stall;
            @(posedge Clk); #1;
            if (!st_now) break;
            stalls++;
            if (stalls > 200) break;
            @(negedge Clk); #1;
        end
        chk("stall_cycles", stalls, exp_st);
    endtask

    initial begin : monitor
        wb_t w;
        forever begin
            @(negedge Clk);
            if (Rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out_valid: got out_valid=1, expected no pending entry");
                end else begin
                    w = sb.pop_front();
                    chk("out_AddrErr", out_AddrErr, w.adderr);
                    chk("out_BusErr", out_BusErr, 0);
                    chk("out_RegWr", out_RegWr, w.regwr);
                    chk("out_MemtoReg", out_MemtoReg, w.m2r);
                    chk("out_Overflow", out_Overflow, w.ovf);
                    chk("out_Rw", out_Rw, w.rw);
                    chk("out_ALUout", out_ALUout, w.alu);
                    if (w.chk_dout) chk("out_Dout", out_Dout, w.dout);
                end
            end
        end
    end

    initial begin : responder
        bus_t b;
        bit ab, acked;
        logic [31:0] rd;
        mem_ack = 1'b0;
        mem_rdata = '0;
        acked = 1'b0;
        forever begin
            @(negedge Clk);
            mem_ack = 1'b0;
            if (acked) chk("mem_req_drop", mem_req, 0);
            acked = 1'b0;
            if (Rst_n && mem_req) begin
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_req: got mem_req=1, expected no request");
                    b = '0;
                    b.addr = mem_addr;
                end else begin
                    b = bq.pop_front();
                    chk("mem_addr", mem_addr, b.addr);
                    chk("mem_we", mem_we, b.we);
                    chk("mem_be", mem_be, b.be);
                    if (b.we) chk("mem_wdata", mem_wdata, b.wdata);
                end
                ab = 1'b0;
                for (int k = 0; k < b.d; k++) begin
                    @(negedge Clk);
                    if (!Rst_n) begin ab = 1'b1; break; end
                    chk("mem_req_held", mem_req, 1);
                end
                if (!ab) begin
                    for (int i = 0; i < 4; i++) rd[8*i +: 8] = bus_b(b.addr + i);
                    mem_rdata = rd;
                    mem_ack = 1'b1;
                    acked = 1'b1;
                    if (mem_we)
                        for (int i = 0; i < 4; i++)
                            if (mem_be[i]) mbus[mem_addr + i] = mem_wdata[8*i +: 8];
                end
            end else if (Rst_n && $urandom_range(0, 7) == 0) begin
                mem_ack = 1'b1;
                mem_rdata = $urandom;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish before time bound");
        $fatal(1);
    end

    initial begin : stim
        op_t o;
        bus_t b;
        issue('0);
        for (int i = 0; i < 4; i++) begin
            mmod[32'h1000 + i] = i == 3 ? 8'h80 : 8'hff;
            mbus[32'h1000 + i] = i == 3 ? 8'h80 : 8'hff;
        end
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_RegWr", out_RegWr, 0);
        chk("rst_out_Dout", out_Dout, 0);
        chk("rst_out_ALUout", out_ALUout, 0);
        chk("rst_out_AddrErr", out_AddrErr, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_Stall", Stall, 0);
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        issue(mk(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 0));
        issue(mk(32'h1003, 5'd6, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 3));
        issue(mk(32'h1003, 5'd7, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0, 3));
        issue(mk(32'h2002, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'hABCD, 1));
        issue(mk(32'h2000, 5'd8, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 0));
        issue(mk(32'h3001, 5'd9, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 0));
        o = mk(32'h55, 5'd1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 0);
        o.branch = 1'b1; o.zero = 1'b1; o.btarg = 32'h40; o.jtarg = 32'h80;
        issue(o);
        o.branch = 1'b0; o.jump = 1'b1;
        issue(o);
        for (int i = 0; i < 300; i++) issue(rand_op());
        issue(mk(32'hDEAD, 5'd3, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 0));
        in_valid = 1'b1; in_MemRd = 1'b1; in_MemWr = 1'b0; in_Size = 2'd2;
        in_ALUout = 32'h104; in_Rw = 5'd7; in_RegWr = 1'b1;
        b = '0;
        b.addr = 32'h104; b.be = 4'hf; b.d = 50;
        bq.push_back(b);
        @(posedge Clk); #1;
        chk("mem_req_issued", mem_req, 1);
        repeat (2) @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_mem_be", mem_be, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_ALUout", out_ALUout, 0);
        chk("midrst_out_Rw", out_Rw, 0);
        in_valid = 1'b0; in_MemRd = 1'b0;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        chk("post_rst_mem_req", mem_req, 0);
        chk("scoreboard_drained", sb.size(), 0);
        chk("bus_queue_drained", bq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_mem_hs.md
Name: stage_mem_hs

Overview:
Parametrised successor to the single-cycle MEM stage. It talks to data memory through a req/ack handshake with variable latency, and supports byte, half and word (and dword when DATA_W=64) loads and stores with sign or zero extension. It detects misaligned accesses and stalls upstream while a memory transaction is outstanding. It resolves PC source and owns the registered MEM/WB pipeline register.

Parameters:
DATA_W, 32, datapath width; 32 or 64 only
ADDR_W, 32, byte address width
RW_W, 5, register-file write address width
TIMEOUT_CYC, 255, bus-timeout limit in cycles (used only with MEM_TIMEOUT_EN)

Ports:
Clk  in  1  clock, all flops on posedge
Rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EX/MEM entry valid
in_Btarg, in_Jtarg  in  ADDR_W  branch / jump targets
in_busB  in  DATA_W  store data
in_ALUout  in  DATA_W  address or ALU result
in_Rw  in  RW_W  destination register
in_Zero, in_Overflow, in_RegWr, in_MemtoReg, in_MemWr, in_MemRd, in_Branch, in_Jump  in  1  EX/MEM controls
in_Size  in  2  0=byte 1=half 2=word 3=dword
in_Unsigned  in  1  zero-extend loads
Stall  out  1  hold EX/MEM and earlier stages
PCSrc  out  1  redirect IF
Btarg_or_Jtarg  out  ADDR_W  redirect target
mem_req, mem_we  out  1  bus request / write
mem_addr  out  ADDR_W  address, aligned down to DATA_W/8
mem_be  out  DATA_W/8  byte enables
mem_wdata  out  DATA_W  lane-replicated store data
mem_ack  in  1  transaction complete, single-cycle pulse
mem_rdata  in  DATA_W  read data, valid with mem_ack
out_valid, out_RegWr, out_MemtoReg, out_Overflow, out_AddrErr, out_BusErr  out  1  MEM/WB register
out_Dout, out_ALUout  out  DATA_W  MEM/WB register
out_Rw  out  RW_W  MEM/WB register

Behaviour:
- Reset: FSM=IDLE; every out_* is 0; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. Stall and PCSrc are 0 while in_valid=0.
- PCSrc = in_valid & (in_Jump | (in_Branch & in_Zero)), combinational. Btarg_or_Jtarg = in_Jump ? in_Jtarg : in_Btarg.
- Non-memory entry (MemRd=MemWr=0): MEM/WB register loads on the next edge; out_valid=in_valid.
- in_valid=0: bubble. Next edge sets out_valid=0 and out_RegWr=0; the other out_* hold.
- Misaligned access: half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0, or Size=3 when DATA_W=32.
  - No bus request is issued.
  - Next edge: out_valid=1, out_AddrErr=1, out_RegWr=0.
- FSM IDLE→REQ: on a valid aligned memory op.
  - Stall=1 combinationally that cycle.
  - Edge: latch addr/be/wdata/controls, assert mem_req (registered), go to REQ.
- FSM in REQ:
  - mem_req held with all bus outputs stable.
  - Stall = ~mem_ack.
- mem_ack in REQ:
  - Same edge: load MEM/WB with out_valid=1, out_Dout = extracted and extended read data (store: out_Dout=0).
  - Drop mem_req, return to IDLE.
  - Minimum memory-op latency is 2 edges.
  - Upstream advances on the ack cycle; a back-to-back memory op enters REQ one cycle later.
- mem_ack in IDLE is ignored.
- Load extraction: lane = addr low bits. Extend sign bit unless in_Unsigned; word load on DATA_W=64 extends to 64.
- Store: mem_be = size mask shifted by lane. mem_wdata = store datum replicated in every lane.
- Flags: MemWr and MemRd both set is treated as a store. out_Overflow is passed through unchanged; the WR stage decides suppression.
- Reset mid-transaction: mem_req deasserts asynchronously, the transaction is abandoned, and no MEM/WB write occurs.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - An 8..16-bit counter clears on entering REQ and increments each REQ cycle.
  - At TIMEOUT_CYC without ack: drop mem_req, out_valid=1, out_BusErr=1, out_RegWr=0, return to IDLE.
  - A late ack is ignored.
- Undefined: REQ waits indefinitely; out_BusErr is tied to 0.

Decomposition:
- Package mem_stage_pkg holds:
  - SIZE_B/H/W/D encodings
  - state enum {IDLE, REQ}
  - be_mask(size, lane) function
  - misalign(size, addr) function
- Sub-module load_align: combinational lane select plus sign/zero extension, instantiated once.

Test Plan:
- Non-memory op, in_ALUout=0x1234, Rw=5, RegWr=1 → one edge later out_valid=1, out_ALUout=0x1234, Stall never asserted.
- lb, addr=0x1003, ack after 3 cycles with rdata=0x80FF_FF_FF → Stall high for 4 cycles, mem_be=4'b1000, out_Dout=0xFFFFFF80; with lbu, out_Dout=0x00000080.
- sh, addr=0x2002, busB=0xABCD → mem_we=1, mem_be=4'b1100, mem_wdata=0xABCDABCD, out_RegWr=0.
- lw, addr=0x3001 → no mem_req, out_AddrErr=1, out_RegWr=0, 1-cycle latency.
- Branch=1, Zero=1, Btarg=0x40 → PCSrc=1, target 0x40 the same cycle. Jump=1 with Jtarg=0x80 → target 0x80.
- Rst_n low during REQ → mem_req=0 immediately, all out_*=0. With MEM_TIMEOUT_EN and no ack: out_BusErr=1 after TIMEOUT_CYC cycles.
